// File: rtl/dac_pkg.sv
// Shared types and helpers for the ramping DAC model: FSM state encoding and
// the code-to-voltage conversion used to drive the real-valued output.
package dac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } dac_state_t;

    // Linear transfer: one code step is vref / 2^bits, code 0 maps to 0.0.
    function automatic real code_to_volts(input int unsigned code,
                                          input int unsigned bits,
                                          input real vref);
        return real'(code) * vref / real'(64'd1 << bits);
    endfunction

endpackage

// File: rtl/dac_slew_step.sv
// Combinational slew limiter: moves cur_code toward target by at most
// SLEW_STEP codes, computed one bit wider so it can never wrap or overshoot.
module dac_slew_step
    import dac_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int SLEW_STEP = 4
) (
    input  logic [BITS-1:0] cur_code,
    input  logic [BITS-1:0] target,
    output logic [BITS-1:0] next_code
);

    localparam logic [BITS:0] STEP_W = (BITS+1)'(SLEW_STEP);

    logic [BITS:0] cur_w;
    logic [BITS:0] tgt_w;
    logic [BITS:0] delta;
    logic [BITS:0] step;
    logic [BITS:0] sum;
    logic          up;

    always_comb begin
        cur_w = {1'b0, cur_code};
        tgt_w = {1'b0, target};
        up    = (tgt_w > cur_w);
        delta = up ? (tgt_w - cur_w) : (cur_w - tgt_w);
        // Clamp to the remaining distance so the last step lands exactly on target.
        if (32'(delta) > 32'(SLEW_STEP)) begin
            step = STEP_W;
        end else begin
            step = delta;
        end
        sum       = up ? (cur_w + step) : (cur_w - step);
        next_code = sum[BITS-1:0];
    end

endmodule

// File: rtl/dac_ramp.sv
// Behavioural DAC with optional output slew limiting (enable with macro
// DAC_SLEW_LIMIT_EN); without it, accepted codes appear on the next edge.
module dac_ramp
    import dac_pkg::*;
#(
    parameter int  BITS      = 8,
    parameter real VREF      = 1.0,
    parameter int  SLEW_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] code_in,
    input  logic            code_valid,
    output logic            code_ready,
    output real             out,
    output logic [BITS-1:0] cur_code,
    output logic            settled
);

    logic [BITS-1:0] cur_code_reg;
    logic [BITS-1:0] target_reg;

`ifdef DAC_SLEW_LIMIT_EN
    dac_state_t      state_reg;
    logic            ready_reg;
    logic            settled_reg;
    logic [BITS-1:0] next_code;

    dac_slew_step #(
        .BITS      (BITS),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .cur_code  (cur_code_reg),
        .target    (target_reg),
        .next_code (next_code)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            target_reg   <= '0;
            cur_code_reg <= '0;
            ready_reg    <= 1'b1;
            settled_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (code_valid) begin
                        target_reg <= code_in;
                        // Re-requesting the current code is accepted but starts no ramp.
                        if (code_in != cur_code_reg) begin
                            state_reg   <= RAMP;
                            ready_reg   <= 1'b0;
                            settled_reg <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    cur_code_reg <= next_code;
                    if (next_code == target_reg) begin
                        state_reg   <= IDLE;
                        ready_reg   <= 1'b1;
                        settled_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign code_ready = ready_reg;
    assign settled    = settled_reg;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_reg   <= '0;
            cur_code_reg <= '0;
        end else if (code_valid) begin
            target_reg   <= code_in;
            cur_code_reg <= code_in;
        end
    end

    // Always ready; both registers load together so they always agree.
    assign code_ready = 1'b1;
    assign settled    = (cur_code_reg == target_reg);
`endif

    assign cur_code = cur_code_reg;
    assign out      = code_to_volts(32'(cur_code_reg), BITS, VREF);

endmodule

// File: tb/tb_dac_ramp.sv
// Directed bench for dac_ramp; expectations follow whichever build
// (slew-limited or direct) the design was compiled with.
module tb_dac_ramp;

    logic       clk;
    logic       rst_n;
    logic [7:0] code_in;
    logic       code_valid;
    logic       code_ready;
    real        out;
    logic [7:0] cur_code;
    logic       settled;

    int n_assert = 0;
    int n_fail   = 0;

    dac_ramp #(
        .BITS      (8),
        .VREF      (1.0),
        .SLEW_STEP (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .out        (out),
        .cur_code   (cur_code),
        .settled    (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0.8f expected=%0.8f", tag, obs, exp);
        end
    endtask

    initial begin
        int cycles;
        rst_n      = 1'b0;
        code_valid = 1'b0;
        code_in    = 8'h00;
        tick();
        tick();
        chk("rst_cur", 32'(cur_code), 32'h0);
        chk_r("rst_out", out, 0.0);
        chk("rst_ready", 32'(code_ready), 32'h1);
        chk("rst_settled", 32'(settled), 32'h1);
        rst_n = 1'b1;
        $display("reset: cur=0x%0h out=%0.8f", cur_code, out);

`ifdef DAC_SLEW_LIMIT_EN
        // Up-ramp 0 -> 0x10 in four steps of 4.
        code_in = 8'h10; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk("up_accept_cur", 32'(cur_code), 32'h0);
        chk("up_accept_ready", 32'(code_ready), 32'h0);
        chk("up_accept_settled", 32'(settled), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("up_cur", 32'(cur_code), 32'(4 * i));
            chk("up_ready", 32'(code_ready), (i == 4) ? 32'h1 : 32'h0);
        end
        chk_r("up_out", out, 0.0625);
        chk("up_settled", 32'(settled), 32'h1);
        $display("up-ramp: cur=0x%0h out=%0.8f", cur_code, out);

        // Down-step of 2 codes is clamped, no undershoot.
        code_in = 8'h0E; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk("dn_ready", 32'(code_ready), 32'h0);
        tick();
        chk("dn_cur", 32'(cur_code), 32'h0E);
        chk("dn_ready_back", 32'(code_ready), 32'h1);
        chk_r("dn_out", out, 0.0546875);
        $display("clamped down: cur=0x%0h out=%0.8f", cur_code, out);

        // 0x0E -> 0x20 takes ceil(18/4)=5 cycles; 0xFF held meanwhile is ignored.
        code_in = 8'h20; code_valid = 1'b1;
        tick();
        code_in = 8'hFF;
        tick(); chk("busy_c1", 32'(cur_code), 32'h12);
        tick(); chk("busy_c2", 32'(cur_code), 32'h16);
        tick(); chk("busy_c3", 32'(cur_code), 32'h1A);
        tick(); chk("busy_c4", 32'(cur_code), 32'h1E);
        tick(); chk("busy_c5", 32'(cur_code), 32'h20);
        chk("busy_ready", 32'(code_ready), 32'h1);
        tick();
        code_valid = 1'b0;
        chk("busy_accept_cur", 32'(cur_code), 32'h20);
        chk("busy_accept_ready", 32'(code_ready), 32'h0);
        cycles = 0;
        while (code_ready !== 1'b1 && cycles < 70) begin
            tick();
            cycles++;
        end
        chk("busy_ramp_cycles", 32'(cycles), 32'd56);
        chk("busy_final_cur", 32'(cur_code), 32'hFF);
        chk_r("busy_final_out", out, 0.99609375);
        $display("busy ignore: cycles=%0d cur=0x%0h out=%0.8f", cycles, cur_code, out);

        // Accepting the current code stays in IDLE.
        code_in = 8'hFF; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        chk("same_ready", 32'(code_ready), 32'h1);
        chk("same_settled", 32'(settled), 32'h1);
        $display("same code: cur=0x%0h ready=%0b", cur_code, code_ready);

        // Reset on the second ramp cycle aborts the ramp; no accept during reset.
        code_in = 8'h00; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        tick();
        chk("mid_step1", 32'(cur_code), 32'hFB);
        rst_n = 1'b0; code_in = 8'h40; code_valid = 1'b1;
        tick();
        chk("mid_rst_cur", 32'(cur_code), 32'h0);
        chk_r("mid_rst_out", out, 0.0);
        chk("mid_rst_ready", 32'(code_ready), 32'h1);
        chk("mid_rst_settled", 32'(settled), 32'h1);
        rst_n = 1'b1; code_valid = 1'b0;
        tick();
        chk("mid_after_cur", 32'(cur_code), 32'h0);
        chk("mid_after_ready", 32'(code_ready), 32'h1);
        $display("reset mid-ramp: cur=0x%0h out=%0.8f", cur_code, out);
`else
        // Direct build: every accepted code appears on the next edge.
        code_in = 8'hFF; code_valid = 1'b1;
        tick();
        chk("dir_ff_cur", 32'(cur_code), 32'hFF);
        chk_r("dir_ff_out", out, 0.99609375);
        chk("dir_ff_ready", 32'(code_ready), 32'h1);
        chk("dir_ff_settled", 32'(settled), 32'h1);
        $display("direct 0xFF: cur=0x%0h out=%0.8f", cur_code, out);

        code_in = 8'h0E;
        tick();
        chk("dir_0e_cur", 32'(cur_code), 32'h0E);
        chk_r("dir_0e_out", out, 0.0546875);
        $display("direct 0x0E: cur=0x%0h out=%0.8f", cur_code, out);

        code_in = 8'h80;
        tick();
        chk_r("dir_80_out", out, 0.5);
        chk("dir_80_ready", 32'(code_ready), 32'h1);
        $display("direct 0x80: cur=0x%0h out=%0.8f", cur_code, out);

        code_in = 8'h01;
        tick();
        chk_r("dir_01_out", out, 0.00390625);
        $display("direct 0x01: cur=0x%0h out=%0.8f", cur_code, out);

        // No accept while in reset, even with valid held.
        rst_n = 1'b0; code_in = 8'h33;
        tick();
        chk("dir_rst_cur", 32'(cur_code), 32'h0);
        chk_r("dir_rst_out", out, 0.0);
        chk("dir_rst_ready", 32'(code_ready), 32'h1);
        chk("dir_rst_settled", 32'(settled), 32'h1);
        rst_n = 1'b1;
        tick();
        chk("dir_post_cur", 32'(cur_code), 32'h33);
        chk("dir_post_settled", 32'(settled), 32'h1);
        code_valid = 1'b0; code_in = 8'hAA;
        tick();
        chk("dir_novalid_cur", 32'(cur_code), 32'h33);
        $display("direct reset: cur=0x%0h out=%0.8f", cur_code, out);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
